// File: rtl/iis_rx_stereo.sv
// I2S stereo receiver: assembles left/right words and presents them as a pair on a valid/ready port.
// Define IIS_RX_LEFT_JUSTIFIED_EN for left-justified timing (slot MSB sampled on the LRCK edge itself).
module iis_rx_stereo #(
  parameter int DW = 24
) (
  input  logic          presetn,
  input  logic          bclk,
  input  logic          LRCK,
  input  logic          datain,
  input  logic          ready,
  output logic [DW-1:0] left_data,
  output logic [DW-1:0] right_data,
  output logic          valid,
  output logic          overrun,
  output logic [1:0]    state_dbg
);
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] DW_C   = CW'(DW);
  localparam logic [CW-1:0] LAST_C = CW'(DW - 1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {SYNC = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

  state_t        state_q;
  logic          lrck_d;
  logic [DW-1:0] shift_q;
  logic [DW-1:0] staging_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] word_nxt;
  logic [DW-1:0] fin_word;
  logic [DW-1:0] first_word;
  logic          slot_edge;
  logic          start;
  logic          start_rise;
  logic          glitch;
  logic          in_slot;
  logic          left_fin;
  logic          right_fin;

  assign slot_edge = LRCK != lrck_d;

`ifdef IIS_RX_LEFT_JUSTIFIED_EN
  assign start      = slot_edge;
  assign start_rise = LRCK;
`else
  // Slot data starts one bclk after the LRCK edge, so the slot start is the delayed edge.
  logic edge_q;
  logic rise_q;
  assign start      = edge_q;
  assign start_rise = rise_q;
`endif

  assign in_slot   = (state_q == LEFT) || (state_q == RIGHT);
  assign glitch    = slot_edge && (((state_q == LEFT) && !LRCK) || ((state_q == RIGHT) && LRCK));
  assign state_dbg = state_q;

  // Bits fill from the MSB down, so a short slot leaves its unfilled LSBs at zero.
  always_comb begin
    word_nxt = shift_q;
    for (int i = 0; i < DW; i++) begin
      if (int'(cnt_q) == DW - 1 - i) word_nxt[i] = datain;
    end
    first_word         = '0;
    first_word[DW-1]   = datain;
    fin_word           = word_nxt;
    left_fin           = 1'b0;
    right_fin          = 1'b0;
    if (in_slot && !glitch) begin
      if (start) begin
        if (cnt_q != DW_C) begin
          fin_word  = shift_q;
          left_fin  = (state_q == LEFT) && start_rise;
          right_fin = (state_q == RIGHT) && !start_rise;
        end
      end else if (cnt_q == LAST_C) begin
        left_fin  = state_q == LEFT;
        right_fin = state_q == RIGHT;
      end
    end
  end

  // Output handshake: a pair is taken at a posedge with valid && ready; while valid is high
  // and ready low the outputs hold, and a further completed pair is dropped and flags overrun.
  always_ff @(posedge bclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= SYNC;
      lrck_d     <= 1'b0;
`ifndef IIS_RX_LEFT_JUSTIFIED_EN
      edge_q     <= 1'b0;
      rise_q     <= 1'b0;
`endif
      shift_q    <= '0;
      staging_q  <= '0;
      cnt_q      <= '0;
      left_data  <= '0;
      right_data <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      lrck_d <= LRCK;
`ifndef IIS_RX_LEFT_JUSTIFIED_EN
      edge_q <= slot_edge;
      rise_q <= LRCK;
`endif
      if (left_fin) staging_q <= fin_word;

      if (right_fin) begin
        if (!valid || ready) begin
          left_data  <= staging_q;
          right_data <= fin_word;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (glitch) begin
        state_q <= SYNC;
        cnt_q   <= '0;
      end else if (start && (state_q == SYNC)) begin
        if (!start_rise) begin
          state_q <= LEFT;
          shift_q <= first_word;
          cnt_q   <= ONE_C;
        end
      end else if (start) begin
        if ((state_q == LEFT) == start_rise) begin
          state_q <= (state_q == LEFT) ? RIGHT : LEFT;
          shift_q <= first_word;
          cnt_q   <= ONE_C;
        end else begin
          state_q <= SYNC;
          cnt_q   <= '0;
        end
      end else if (in_slot && (cnt_q != DW_C)) begin
        shift_q <= word_nxt;
        cnt_q   <= cnt_q + ONE_C;
      end
    end
  end

endmodule

// File: doc/iis_rx_stereo.md
IIS_RX_STEREO -- requirements
Module: iis_rx_stereo

Interface
REQ-001 Parameter DW, default 24: received word width in bits; legal range 8..32.
REQ-002 presetn  input  1  asynchronous active-low reset.
REQ-003 bclk  input  1  serial bit clock; all logic on posedge bclk.
REQ-004 LRCK  input  1  word select; 0 = left channel, 1 = right channel.
REQ-005 datain  input  1  serial data, MSB first.
REQ-006 left_data  output  DW  last completed left word.
REQ-007 right_data  output  DW  last completed right word.
REQ-008 valid  output  1  left_data/right_data hold a new stereo pair.
REQ-009 ready  input  1  consumer accepts the pair when valid and ready are both high at a posedge.
REQ-010 overrun  output  1  sticky flag: a completed pair was dropped.

Function
REQ-011 The block SHALL register LRCK every posedge into lrck_d; a slot edge is the posedge where LRCK != lrck_d.
REQ-012 Without the configuration macro, slot bit 0 (MSB) SHALL be datain sampled one posedge after the slot edge (standard one-bit delay).
REQ-013 The FSM SHALL have states SYNC, LEFT, RIGHT; reset enters SYNC.
REQ-014 SYNC -> LEFT only on a falling slot edge (LRCK 1->0); all data before it is discarded.
REQ-015 LEFT -> RIGHT on a rising slot edge; RIGHT -> LEFT on a falling slot edge.
REQ-016 An edge of the wrong polarity for the current state (glitch) SHALL return the FSM to SYNC and discard the partial pair.
REQ-017 Per slot, the block SHALL shift in exactly DW bits; bits beyond DW in a slot are ignored.
REQ-018 If a slot ends with fewer than DW bits captured, the word SHALL complete with unfilled LSBs zero.
- In standard mode, a slot ends at the posedge where the next slot's bit 0 would be sampled.
REQ-019 A completed left word SHALL be held in a staging register; it is not visible on left_data until the matching right word completes.
REQ-020 On right word completion, if valid is low, or valid and ready are both high at that posedge, the block SHALL load left_data/right_data and assert valid on the next cycle.
- Latency: 1 bclk after the posedge sampling the right word's last bit.
REQ-021 valid SHALL fall the cycle after a posedge with valid && ready, unless a new pair loads at that posedge.
REQ-022 If a pair completes while valid is high and ready is low, the new pair SHALL be dropped, the outputs unchanged, and overrun set to 1.
REQ-023 overrun SHALL remain 1 until reset.
REQ-024 The bit counter SHALL saturate at DW; it never wraps within a slot.

Reset
REQ-025 Asserting presetn low SHALL immediately clear left_data, right_data, valid, overrun, lrck_d, the shift and staging registers, and the bit counter, and force state SYNC.
REQ-026 After deassertion mid-frame, no pair SHALL be output until the first complete left+right frame following a falling LRCK edge.

Configuration
REQ-027 Macro IIS_RX_LEFT_JUSTIFIED_EN defined: slot bit 0 SHALL be datain sampled at the slot-edge posedge itself (no one-bit delay); slot end is the next slot edge.
REQ-028 Macro absent: standard I2S timing per REQ-012; all other behaviour is identical.

Verification
REQ-029 DW=24, 32-bit slots, standard mode, ready=1; send L=0x123456, R=0xABCDEF -> valid pulses 1 cycle, left_data=0x123456, right_data=0xABCDEF.
REQ-030 DW=24, 16-bit slots; L=0x1234, R=0xBEEF -> left_data=0x123400, right_data=0xBEEF00.
REQ-031 ready=0, two consecutive frames (0x000001/0x000002 then 0x000003/0x000004) -> outputs hold the first pair, overrun=1; ready=1 -> valid drops, overrun stays 1.
REQ-032 IIS_RX_LEFT_JUSTIFIED_EN defined, DW=16, MSB aligned to the LRCK edge, L=0x8001, R=0x7FFE -> left_data=0x8001, right_data=0x7FFE.
REQ-033 presetn pulsed low mid-right-slot -> all outputs 0 at once; the next valid reflects only the first full frame after the next falling LRCK edge.
REQ-034 LRCK glitch (extra rising edge while in RIGHT) -> FSM to SYNC, no valid for that frame, overrun unchanged.
